// File: rtl/qsyssystem_processor_ociram_arbiter_if.sv
// Bus bundle for the OCI RAM arbiter: CPU slave port, JTAG debug port and RAM port.
// The slave modport is the arbiter's view; master is the surrounding system (CPU, debug, RAM).
interface qsyssystem_processor_ociram_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_waitrequest;
    logic [31:0]       cpu_readdata;

    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [31:0]       MonDReg;
    logic              jtag_busy;
    logic              jtag_overrun;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_wren;
    logic              ram_rden;
    logic [31:0]       ram_q;

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable,
        output cpu_waitrequest, cpu_readdata,
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output MonDReg, jtag_busy, jtag_overrun,
        output ram_addr, ram_wdata, ram_be, ram_wren, ram_rden,
        input  ram_q
    );

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable,
        input  cpu_waitrequest, cpu_readdata,
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  MonDReg, jtag_busy, jtag_overrun,
        input  ram_addr, ram_wdata, ram_be, ram_wren, ram_rden,
        output ram_q
    );
endinterface

// File: rtl/qsyssystem_processor_ociram_arbiter.sv
// OCI RAM arbiter: shares one single-port RAM between the CPU slave and the JTAG debug path.
// Define OCIRAM_ARB_ROUND_ROBIN_EN for round-robin conflict arbitration; otherwise debug wins.
module qsyssystem_processor_ociram_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    qsyssystem_processor_ociram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CPU_RD = 2'd1, JTAG_RD = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              overrun_q, overrun_d;
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
    logic              dbg_won_last_q, dbg_won_last_d;
`endif

    logic              cpu_req;
    logic              dbg_pri;
    logic              dbg_done;
    logic              dec_op, dec_wr, dec_load;
    logic [31:0]       dec_data;
    logic [ADDR_W-1:0] jdo_addr;
    logic              unused_jdo;

    logic              waitrequest;
    logic [31:0]       readdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_wren, ram_rden;

    assign cpu_req    = bus.cpu_read | bus.cpu_write;
    assign jdo_addr   = ADDR_W'(bus.jdo[24:17]);
    assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};

`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
    assign dbg_pri = ~dbg_won_last_q;
`else
    assign dbg_pri = 1'b1;
`endif

    // take_action_ocimem_a masks the other pulses in the same cycle.
    always_comb begin
        dec_op   = 1'b0;
        dec_wr   = 1'b0;
        dec_load = 1'b0;
        dec_data = '0;
        if (bus.take_action_ocimem_a) begin
            dec_load = 1'b1;
            dec_op   = bus.jdo[35];
        end else if (bus.take_action_ocimem_b) begin
            dec_op   = 1'b1;
            dec_wr   = 1'b1;
            dec_data = bus.jdo[34:3];
        end else if (bus.take_no_action_ocimem_a) begin
            dec_op   = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_wr_d   = pend_wr_q;
        pend_data_d = pend_data_q;
        dbg_addr_d  = dbg_addr_q;
        mon_dreg_d  = mon_dreg_q;
        overrun_d   = overrun_q;
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
        dbg_won_last_d = dbg_won_last_q;
`endif
        dbg_done    = 1'b0;
        waitrequest = 1'b1;
        readdata    = '0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_be      = '0;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;

        // Outputs are gated by reset_n so the RAM and CPU ports stay quiet while reset is held.
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (pending_q && (!cpu_req || dbg_pri)) begin
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
                        if (cpu_req) dbg_won_last_d = 1'b1;
`endif
                        ram_addr = dbg_addr_q;
                        if (pend_wr_q) begin
                            ram_wren  = 1'b1;
                            ram_wdata = pend_data_q;
                            ram_be    = 4'hF;
                            dbg_done  = 1'b1;
                        end else begin
                            ram_rden = 1'b1;
                            state_d  = JTAG_RD;
                        end
                    end else if (cpu_req) begin
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
                        if (pending_q) dbg_won_last_d = 1'b0;
`endif
                        ram_addr = bus.cpu_address;
                        if (bus.cpu_write) begin
                            ram_wren    = 1'b1;
                            ram_wdata   = bus.cpu_writedata;
                            ram_be      = bus.cpu_byteenable;
                            waitrequest = 1'b0;
                        end else begin
                            ram_rden = 1'b1;
                            state_d  = CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    waitrequest = 1'b0;
                    readdata    = bus.ram_q;
                    state_d     = IDLE;
                end
                JTAG_RD: begin
                    mon_dreg_d = bus.ram_q;
                    dbg_done   = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Completion needs pending set, so it never collides with a fresh address load.
        if (dbg_done) begin
            pending_d  = 1'b0;
            dbg_addr_d = dbg_addr_q + ADDR_W'(1);
        end else if (dec_load && !pending_q) begin
            dbg_addr_d = jdo_addr;
        end

        if (dec_op) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d   = 1'b1;
                pend_wr_d   = dec_wr;
                pend_data_d = dec_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_data_q <= '0;
            dbg_addr_q  <= '0;
            mon_dreg_q  <= '0;
            overrun_q   <= 1'b0;
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
            dbg_won_last_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_wr_q   <= pend_wr_d;
            pend_data_q <= pend_data_d;
            dbg_addr_q  <= dbg_addr_d;
            mon_dreg_q  <= mon_dreg_d;
            overrun_q   <= overrun_d;
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
            dbg_won_last_q <= dbg_won_last_d;
`endif
        end
    end

    assign bus.cpu_waitrequest = waitrequest;
    assign bus.cpu_readdata    = readdata;
    assign bus.MonDReg         = mon_dreg_q;
    assign bus.jtag_busy       = pending_q;
    assign bus.jtag_overrun    = overrun_q;
    assign bus.ram_addr        = ram_addr;
    assign bus.ram_wdata       = ram_wdata;
    assign bus.ram_be          = ram_be;
    assign bus.ram_wren        = ram_wren;
    assign bus.ram_rden        = ram_rden;
endmodule

// File: tb/tb_qsyssystem_processor_ociram_arbiter.sv
// Testbench for qsyssystem_processor_ociram_arbiter: directed scenarios followed by random CPU/debug
// traffic, checked cycle by cycle against a transaction-level model with its own reference memory.
module tb_qsyssystem_processor_ociram_arbiter;
    localparam int unsigned ADDR_W = 8;
`ifdef OCIRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    qsyssystem_processor_ociram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    qsyssystem_processor_ociram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];

    // Model: which read result is due this cycle (0 none, 1 CPU, 2 debug) plus debug-side state.
    int          ret_kind;
    logic [7:0]  cpu_rd_addr;
    bit          m_pend, m_pend_wr, m_ovr, m_dbg_last;
    logic [31:0] m_pend_data, m_mon;
    logic [7:0]  m_addr;

    logic        obs_wait, obs_wren, obs_rden;
    logic [31:0] obs_rdata, obs_wdata;
    logic [7:0]  obs_addr;
    logic [3:0]  obs_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        ret_kind = 0; cpu_rd_addr = '0;
        m_pend = 0; m_pend_wr = 0; m_ovr = 0; m_dbg_last = 0;
        m_pend_data = '0; m_mon = '0; m_addr = '0;
    endtask

    task automatic clear_inputs();
        bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_address = '0;
        bus.cpu_writedata = '0; bus.cpu_byteenable = '0; bus.jdo = '0;
        bus.take_action_ocimem_a = 0; bus.take_action_ocimem_b = 0; bus.take_no_action_ocimem_a = 0;
    endtask

    // Called at a negedge with inputs applied; checks this cycle, advances the model, ends at next negedge.
    task automatic step(output bit cpu_done);
        bit          cpu_req, dbg_go, dbg_done, dec_op, dec_wr, dec_load, pend_old;
        logic [31:0] dec_data, e_rdata, e_wdata, new_mon;
        logic [7:0]  e_addr;
        logic [3:0]  e_be;
        logic        e_wait, e_wren, e_rden;
        int          nxt_ret;
        #1;
        e_wait = 1; e_rdata = '0; e_wdata = '0; e_addr = '0; e_be = '0; e_wren = 0; e_rden = 0;
        nxt_ret = 0; dbg_done = 0; new_mon = m_mon;
        cpu_req = bus.cpu_read || bus.cpu_write;
        if (ret_kind == 1) begin
            e_wait = 0;
            e_rdata = ref_mem[cpu_rd_addr];
        end else if (ret_kind == 2) begin
            new_mon = ref_mem[m_addr];
            dbg_done = 1;
        end else begin
            dbg_go = m_pend && (!cpu_req || !RR_MODE || !m_dbg_last);
            if (dbg_go) begin
                if (cpu_req) m_dbg_last = 1;
                e_addr = m_addr;
                if (m_pend_wr) begin
                    e_wren = 1; e_wdata = m_pend_data; e_be = 4'hF;
                    ref_mem[m_addr] = m_pend_data;
                    dbg_done = 1;
                end else begin
                    e_rden = 1; nxt_ret = 2;
                end
            end else if (cpu_req) begin
                if (m_pend) m_dbg_last = 0;
                e_addr = bus.cpu_address;
                if (bus.cpu_write) begin
                    e_wren = 1; e_wait = 0; e_wdata = bus.cpu_writedata; e_be = bus.cpu_byteenable;
                    ref_mem[bus.cpu_address] = merge(ref_mem[bus.cpu_address], bus.cpu_writedata,
                                                     bus.cpu_byteenable);
                end else begin
                    e_rden = 1; nxt_ret = 1; cpu_rd_addr = bus.cpu_address;
                end
            end
        end

        chk("waitrequest", bus.cpu_waitrequest, e_wait);
        chk("readdata", bus.cpu_readdata, e_rdata);
        chk("ram_wren", bus.ram_wren, e_wren);
        chk("ram_rden", bus.ram_rden, e_rden);
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_wdata", bus.ram_wdata, e_wdata);
        chk("ram_be", bus.ram_be, e_be);
        chk("jtag_busy", bus.jtag_busy, m_pend);
        chk("jtag_overrun", bus.jtag_overrun, m_ovr);
        chk("MonDReg", bus.MonDReg, m_mon);

        obs_wait = bus.cpu_waitrequest; obs_rdata = bus.cpu_readdata;
        obs_wren = bus.ram_wren; obs_rden = bus.ram_rden; obs_addr = bus.ram_addr;
        obs_wdata = bus.ram_wdata; obs_be = bus.ram_be;

        dec_op = 0; dec_wr = 0; dec_load = 0; dec_data = '0;
        if (bus.take_action_ocimem_a) begin
            dec_load = 1; dec_op = bus.jdo[35];
        end else if (bus.take_action_ocimem_b) begin
            dec_op = 1; dec_wr = 1; dec_data = bus.jdo[34:3];
        end else if (bus.take_no_action_ocimem_a) begin
            dec_op = 1;
        end
        pend_old = m_pend;
        if (dbg_done) begin
            m_pend = 0;
            m_addr = m_addr + 8'd1;
        end else if (dec_load && !pend_old) begin
            m_addr = bus.jdo[24:17];
        end
        if (dec_op) begin
            if (pend_old) m_ovr = 1;
            else begin
                m_pend = 1; m_pend_wr = dec_wr; m_pend_data = dec_data;
            end
        end
        m_mon = new_mon;
        ret_kind = nxt_ret;
        cpu_done = !e_wait;

        @(posedge clk);
        #1;
        if (obs_rden) bus.ram_q = env_mem[obs_addr];
        if (obs_wren) env_mem[obs_addr] = merge(env_mem[obs_addr], obs_wdata, obs_be);
        @(negedge clk);
        bus.take_action_ocimem_a = 0; bus.take_action_ocimem_b = 0; bus.take_no_action_ocimem_a = 0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_waitrequest", bus.cpu_waitrequest, 1);
        chk("rst_readdata", bus.cpu_readdata, 0);
        chk("rst_busy", bus.jtag_busy, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_rden", bus.ram_rden, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_be", bus.ram_be, 0);
        chk("rst_overrun", bus.jtag_overrun, 0);
        chk("rst_mondreg", bus.MonDReg, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        bit d;
        for (int k = 0; k < 20 && (m_pend || ret_kind != 0); k++) step(d);
        chk("drain_busy", bus.jtag_busy, 0);
    endtask

    initial begin
        bit          done;
        bit          cpu_on;
        int unsigned kind;
        logic [2:0]  p;
        logic [63:0] r64;

        for (int i = 0; i < 256; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        clear_inputs();
        model_reset();
        @(negedge clk);
        bus.cpu_write = 1;  // request held through reset must stay invisible on the RAM port
        apply_reset();

        // CPU write then 2-cycle read at 0x10
        bus.cpu_address = 8'h10; bus.cpu_writedata = 32'hDEADBEEF; bus.cpu_byteenable = 4'hF;
        step(done);
        chk("cpu_wr_wren", obs_wren, 1);
        chk("cpu_wr_wait", obs_wait, 0);
        bus.cpu_write = 0; bus.cpu_read = 1;
        step(done);
        chk("cpu_rd_c1_wait", obs_wait, 1);
        step(done);
        chk("cpu_rd_c2_wait", obs_wait, 0);
        chk("cpu_rd_data", obs_rdata, 32'hDEADBEEF);
        bus.cpu_read = 0;

        // Debug read at 0xFF, then at the wrapped address 0x00
        bus.jdo = '0; bus.jdo[24:17] = 8'hFF; bus.jdo[35] = 1'b1; bus.take_action_ocimem_a = 1;
        step(done);
        drain();
        chk("dbg_rd_ff_mon", bus.MonDReg, ref_mem[8'hFF]);
        bus.take_no_action_ocimem_a = 1;
        step(done);
        drain();
        chk("dbg_rd_00_mon", bus.MonDReg, ref_mem[8'h00]);

        // Debug write arriving while a debug read is pending is dropped
        bus.take_no_action_ocimem_a = 1;
        step(done);
        bus.jdo[34:3] = 32'h12345678; bus.take_action_ocimem_b = 1;
        step(done);
        chk("overrun_set", bus.jtag_overrun, 1);
        drain();
        repeat (3) step(done);
        chk("overrun_sticky", bus.jtag_overrun, 1);
        chk("dropped_wr_mem", env_mem[8'h02], ref_mem[8'h02]);

        // CPU read held against pending debug writes
        bus.jdo[34:3] = 32'hA5A50001; bus.take_action_ocimem_b = 1; bus.cpu_address = 8'h20;
        step(done);
        bus.cpu_read = 1;
        step(done);
        chk("conflict1_dbg_wins", obs_wren, 1);
        chk("conflict1_cpu_wait", obs_wait, 1);
        step(done);
        chk("conflict1_cpu_next", obs_rden, 1);
        bus.jdo[34:3] = 32'hA5A50002; bus.take_action_ocimem_b = 1;
        step(done);
        chk("cpu_rd_complete", obs_wait, 0);
        step(done);
        chk("conflict2_winner_dbg", obs_wren, RR_MODE ? 1'b0 : 1'b1);
        for (int k = 0; k < 6 && bus.cpu_read; k++) begin
            step(done);
            if (done) bus.cpu_read = 0;
        end
        bus.cpu_read = 0;
        drain();
        chk("conflict_wr_mem", env_mem[8'h03], 32'hA5A50002);

        // Reset during CPU_RD
        bus.cpu_read = 1; bus.cpu_address = 8'h10;
        step(done);
        apply_reset();
        bus.cpu_read = 0;
        chk("post_rst_mon", bus.MonDReg, 0);
        chk("post_rst_overrun", bus.jtag_overrun, 0);

        // Reset during JTAG_RD
        bus.take_no_action_ocimem_a = 1;
        step(done);
        step(done);
        apply_reset();
        chk("jtag_rd_abort_mon", bus.MonDReg, 0);

        // Random traffic
        cpu_on = 0;
        for (int n = 0; n < 600; n++) begin
            if (!cpu_on && $urandom_range(0, 2) == 0) begin
                cpu_on = 1;
                kind = $urandom_range(0, 4);
                bus.cpu_read = (kind < 2) || (kind == 4);
                bus.cpu_write = (kind >= 2);
                bus.cpu_address = 8'($urandom_range(0, 15));
                bus.cpu_writedata = $urandom;
                bus.cpu_byteenable = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3) == 0) begin
                r64 = {$urandom, $urandom};
                bus.jdo = r64[37:0];
                bus.jdo[24:17] = 8'($urandom_range(0, 15));
                p = 3'($urandom_range(1, 7));
                bus.take_action_ocimem_a = p[0];
                bus.take_action_ocimem_b = p[1];
                bus.take_no_action_ocimem_a = p[2];
            end
            step(done);
            if (done) begin
                cpu_on = 0;
                bus.cpu_read = 0;
                bus.cpu_write = 0;
            end
        end
        bus.cpu_read = 0; bus.cpu_write = 0;
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", env_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/qsyssystem_processor_ociram_arbiter.md
QSYSSYSTEM_PROCESSOR_OCIRAM_ARBITER -- requirements
Module: qsyssystem_processor_ociram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, OCI RAM word-address width; jdo bit fields below assume 8.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have CPU-side ports: cpu_read, cpu_write (in, 1), cpu_address (in, ADDR_W), cpu_writedata (in, 32), cpu_byteenable (in, 4), cpu_waitrequest (out, 1), cpu_readdata (out, 32).
REQ-005 SHALL have debug-side ports: jdo (in, 38), take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a (in, 1, single-cycle pulses).
REQ-006 SHALL have debug-side outputs: MonDReg (out, 32, last debug read data), jtag_busy (out, 1), jtag_overrun (out, 1, sticky).
REQ-007 SHALL have RAM ports: ram_addr (out, ADDR_W), ram_wdata (out, 32), ram_be (out, 4), ram_wren, ram_rden (out, 1), ram_q (in, 32, valid exactly 1 cycle after ram_rden).

Function
REQ-008 SHALL decode debug pulses: take_action_ocimem_a loads debug address from jdo[24:17], and when jdo[35]=1 also queues a read; take_action_ocimem_b queues a write of jdo[34:3] with ram_be=4'hF; take_no_action_ocimem_a queues a read.
REQ-009 SHALL hold at most one queued debug op in a pending register; jtag_busy=1 from the cycle after the pulse until the op completes.
REQ-010 SHALL drop any decoded debug op arriving while pending is set and set jtag_overrun, which stays set until reset.
REQ-011 SHALL give take_action_ocimem_a priority over any other pulse in the same cycle; the other pulses are ignored and do not set jtag_overrun.
REQ-012 SHALL post-increment the debug address after every completed debug read or write, wrapping 2^ADDR_W-1 to 0.
REQ-013 SHALL use FSM states IDLE, CPU_RD, JTAG_RD; grants are issued only in IDLE.
REQ-014 In IDLE with a granted CPU write SHALL drive ram_wren=1 with cpu_address/cpu_writedata/cpu_byteenable and cpu_waitrequest=0 in the same cycle (1-cycle write), staying in IDLE.
REQ-015 In IDLE with a granted CPU read SHALL pulse ram_rden and go to CPU_RD; in CPU_RD SHALL drive cpu_readdata=ram_q and cpu_waitrequest=0, then return to IDLE (2-cycle read).
REQ-016 A granted debug write SHALL complete in one IDLE cycle (ram_wren=1); a granted debug read SHALL pulse ram_rden, go to JTAG_RD, capture ram_q into MonDReg there, then return to IDLE.
REQ-017 cpu_waitrequest SHALL be 1 in every cycle except a CPU completion cycle; cpu_read and cpu_write both set SHALL be treated as a write.
REQ-018 ram_wren and ram_rden SHALL never be asserted in the same cycle; SHALL never both be driven for CPU and debug in one cycle.
REQ-019 Arbitration SHALL follow REQ-026/REQ-027 when CPU request and debug pending coincide in IDLE.

Reset
REQ-020 On reset_n low SHALL asynchronously force state IDLE and clear pending, debug address, MonDReg, jtag_overrun, and the round-robin pointer.
REQ-021 SHALL hold cpu_waitrequest=1, cpu_readdata=0, jtag_busy=0, ram_wren=0, ram_rden=0, ram_addr=0, ram_wdata=0, ram_be=0 during reset.
REQ-022 Reset asserted mid-read SHALL abort the read; no data is returned and MonDReg is not updated.
REQ-023 Deassertion SHALL take effect at the first rising clk edge after reset_n goes high.

Configuration
REQ-024 SHALL use the macro OCIRAM_ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-025 The arbitration policy SHALL be the only difference between builds with and without the macro.
REQ-026 With OCIRAM_ARB_ROUND_ROBIN_EN defined: on conflict, the requester not granted last SHALL win; the pointer updates only on a conflict grant.
REQ-027 Without the macro: on conflict, debug pending SHALL always win (fixed priority).

Verification
REQ-028 CPU write addr 0x10 data 0xDEADBEEF be 0xF, no debug traffic -> ram_wren=1 same cycle, cpu_waitrequest=0 same cycle; CPU read 0x10 -> cpu_readdata=0xDEADBEEF on 2nd cycle.
REQ-029 take_action_ocimem_a with jdo[24:17]=0xFF and jdo[35]=1, then take_no_action_ocimem_a after completion -> reads at 0xFF then 0x00, MonDReg updated each time, jtag_busy low after each.
REQ-030 Debug write pulse while a debug read is pending -> write dropped, jtag_overrun=1 until reset.
REQ-031 CPU read held high with a debug write pending in the same IDLE cycle, round-robin build -> debug then CPU alternately; fixed build -> debug first, CPU stalled with waitrequest=1.
REQ-032 reset_n low during CPU_RD -> state IDLE, cpu_waitrequest=1, no readdata; MonDReg=0 and jtag_overrun=0 after release.
